// File: rtl/wb_flash_pkg.sv
// Shared types and constants for the Wishbone-to-parallel-flash bridge.
package wb_flash_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_BEAT,
      ST_RD_ACK,
      ST_WR_SETUP,
      ST_WR_PULSE,
      ST_WR_HOLD,
      ST_TERM
   } fsm_state_e;

   localparam int DEF_WS    = 5;
   localparam int DEF_DW    = 32;
   localparam int DEF_FW    = 8;
   localparam int DEF_CNT_W = $clog2(DEF_WS + 1);

   function automatic int beats(input int dw, input int fw);
      return dw / fw;
   endfunction

   // Beat index needs at least one bit even when a word is a single beat.
   function automatic int beat_idx_w(input int dw, input int fw);
      return (dw / fw > 1) ? $clog2(dw / fw) : 1;
   endfunction

   localparam int BEATS      = beats(DEF_DW, DEF_FW);
   localparam int BEAT_IDX_W = beat_idx_w(DEF_DW, DEF_FW);

endpackage

// File: rtl/flash_ws_counter.sv
// Loadable saturating down-counter; tc_o marks the last cycle of a timed interval.
module flash_ws_counter
   import wb_flash_pkg::*;
#(
   parameter int W = DEF_CNT_W
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/wb_flash_ctrl.sv
// Wishbone classic slave reading a narrow parallel flash in big-endian beats.
// Define WB_FLASH_WRITE_EN to add single-beat command writes; otherwise writes end in wb_err_o.
module wb_flash_ctrl
   import wb_flash_pkg::*;
#(
   parameter int AW = 22,
   parameter int DW = 32,
   parameter int FW = 8,
   parameter int WS = DEF_WS
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic [31:0]     wb_adr_i,
   input  logic [DW-1:0]   wb_dat_i,
   input  logic [DW/8-1:0] wb_sel_i,
   input  logic            wb_we_i,
   input  logic            wb_stb_i,
   input  logic            wb_cyc_i,
   output logic [DW-1:0]   wb_dat_o,
   output logic            wb_ack_o,
   output logic            wb_err_o,
   output logic [AW-1:0]   flash_adr_o,
   input  logic [FW-1:0]   flash_dat_i,
   output logic [FW-1:0]   flash_dat_o,
   output logic            flash_dat_oe,
   output logic            flash_ce,
   output logic            flash_oe,
   output logic            flash_we,
   output logic            flash_rst
);

   localparam int NB  = beats(DW, FW);
   localparam int BIW = beat_idx_w(DW, FW);
   localparam int CW  = $clog2(WS + 1);

   fsm_state_e      state_q, state_d;
   logic [BIW-1:0]  beat_q;
   logic [DW-1:0]   asm_q, asm_nxt;
   logic [DW-1:0]   wb_dat_q;
   logic            wb_ack_q, wb_err_q;
   logic [AW-1:0]   flash_adr_q;
   logic [FW-1:0]   flash_dat_q;
   logic            flash_dat_oe_q, flash_ce_q, flash_oe_q, flash_we_q;
   logic            req, live, last_beat, tc, cnt_load;
   logic [CW-1:0]   cnt_val;
   logic            unused_ok;

   assign live      = wb_cyc_i & wb_stb_i;
   assign req       = (state_q == ST_IDLE) & live & ~wb_ack_q & ~wb_err_q;
   assign last_beat = (beat_q == BIW'(NB - 1));
   // Earlier beats shift toward the MSBs, so beat 0 lands on top.
   assign asm_nxt   = (asm_q << FW) | DW'(flash_dat_i);
   assign unused_ok = ^{wb_sel_i, wb_adr_i, wb_dat_i};

   flash_ws_counter #(.W(CW)) u_ws (
      .clk_i      (wb_clk_i),
      .rst_i      (wb_rst_i),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .tc_o       (tc)
   );

   always_comb begin
      state_d  = state_q;
      cnt_load = 1'b0;
      cnt_val  = CW'(WS);
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               if (!wb_we_i) begin
                  state_d  = ST_RD_BEAT;
                  cnt_load = 1'b1;
               end else begin
`ifdef WB_FLASH_WRITE_EN
                  state_d = ST_WR_SETUP;
`else
                  state_d = ST_TERM;
`endif
               end
            end
         end
         ST_RD_BEAT: begin
            if (!live)
               state_d = ST_IDLE;
            else if (tc) begin
               if (last_beat)
                  state_d = ST_RD_ACK;
               else
                  cnt_load = 1'b1;
            end
         end
         ST_WR_SETUP: begin
            if (!live)
               state_d = ST_IDLE;
            else begin
               state_d  = ST_WR_PULSE;
               cnt_load = 1'b1;
               cnt_val  = CW'(WS - 1);
            end
         end
         ST_WR_PULSE: begin
            if (!live)
               state_d = ST_IDLE;
            else if (tc)
               state_d = ST_WR_HOLD;
         end
         ST_WR_HOLD: state_d = live ? ST_TERM : ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Strobes and terminations decode the next state so they line up with it.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q        <= ST_IDLE;
         beat_q         <= '0;
         asm_q          <= '0;
         wb_dat_q       <= '0;
         wb_ack_q       <= 1'b0;
         wb_err_q       <= 1'b0;
         flash_adr_q    <= '0;
         flash_dat_q    <= '0;
         flash_dat_oe_q <= 1'b0;
         flash_ce_q     <= 1'b1;
         flash_oe_q     <= 1'b1;
         flash_we_q     <= 1'b1;
      end else begin
         state_q        <= state_d;
         flash_ce_q     <= !(state_d inside {ST_RD_BEAT, ST_RD_ACK, ST_WR_SETUP,
                                             ST_WR_PULSE, ST_WR_HOLD});
         flash_oe_q     <= (state_d != ST_RD_BEAT);
         flash_we_q     <= (state_d != ST_WR_PULSE);
         flash_dat_oe_q <= (state_d inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD});
`ifdef WB_FLASH_WRITE_EN
         wb_ack_q       <= (state_d == ST_RD_ACK) || (state_d == ST_TERM);
         wb_err_q       <= 1'b0;
         if (req && wb_we_i) begin
            flash_adr_q <= wb_adr_i[AW-1:0];
            flash_dat_q <= wb_dat_i[FW-1:0];
         end
`else
         wb_ack_q       <= (state_d == ST_RD_ACK);
         wb_err_q       <= (state_d == ST_TERM);
`endif
         if (req && !wb_we_i) begin
            flash_adr_q <= wb_adr_i[AW-1:0] & ~AW'(DW/8 - 1);
            beat_q      <= '0;
         end
         if (state_q == ST_RD_BEAT && tc) begin
            asm_q <= asm_nxt;
            if (!last_beat) begin
               beat_q      <= beat_q + BIW'(1);
               flash_adr_q <= flash_adr_q + AW'(FW/8);
            end
         end
         if (state_d == ST_RD_ACK)
            wb_dat_q <= asm_nxt;
      end
   end

   assign wb_dat_o     = wb_dat_q;
   assign wb_ack_o     = wb_ack_q;
   assign wb_err_o     = wb_err_q;
   assign flash_adr_o  = flash_adr_q;
   assign flash_dat_o  = flash_dat_q;
   assign flash_dat_oe = flash_dat_oe_q;
   assign flash_ce     = flash_ce_q;
   assign flash_oe     = flash_oe_q;
   assign flash_we     = flash_we_q;
   assign flash_rst    = !wb_rst_i;

endmodule

// File: tb/tb_wb_flash_ctrl.sv
// Bench for wb_flash_ctrl: an 8-bit/WS=5 instance and a 16-bit/WS=2 instance share one flash image.
module tb_wb_flash_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        cyc[2], stb[2], we[2];
   logic [31:0] adr[2], wdat[2], dat[2];
   logic        ack[2], err[2], doe[2], ce[2], oe[2], fwe[2], frst[2];
   logic [21:0] fadr[2];
   logic [7:0]  fdi0, fdo0;
   logic [15:0] fdi1, fdo1;
   logic [7:0]  mem [0:1023];
   int checks = 0, failures = 0;

   wb_flash_ctrl #(.AW(22), .DW(32), .FW(8), .WS(5)) u0 (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]),
      .wb_sel_i(4'hF), .wb_we_i(we[0]), .wb_stb_i(stb[0]), .wb_cyc_i(cyc[0]),
      .wb_dat_o(dat[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]),
      .flash_adr_o(fadr[0]), .flash_dat_i(fdi0), .flash_dat_o(fdo0),
      .flash_dat_oe(doe[0]), .flash_ce(ce[0]), .flash_oe(oe[0]),
      .flash_we(fwe[0]), .flash_rst(frst[0]));

   wb_flash_ctrl #(.AW(22), .DW(32), .FW(16), .WS(2)) u1 (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]),
      .wb_sel_i(4'hF), .wb_we_i(we[1]), .wb_stb_i(stb[1]), .wb_cyc_i(cyc[1]),
      .wb_dat_o(dat[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]),
      .flash_adr_o(fadr[1]), .flash_dat_i(fdi1), .flash_dat_o(fdo1),
      .flash_dat_oe(doe[1]), .flash_ce(ce[1]), .flash_oe(oe[1]),
      .flash_we(fwe[1]), .flash_rst(frst[1]));

   // Flash devices: byte-wide and big-endian halfword-wide views of one image.
   assign fdi0 = mem[fadr[0][9:0]];
   assign fdi1 = {mem[fadr[1][9:0]], mem[fadr[1][9:0] + 10'd1]};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: a read returns the aligned 4-byte word big-endian after 1+beats*(WS+1) cycles.
   function automatic logic [31:0] model_rd(input logic [31:0] a);
      logic [9:0] b;
      b = a[9:0] & 10'h3FC;
      return {mem[b], mem[b + 10'd1], mem[b + 10'd2], mem[b + 10'd3]};
   endfunction

   function automatic int model_lat(input int d);
      return (d == 0) ? 1 + (32/8) * (5 + 1) : 1 + (32/16) * (2 + 1);
   endfunction

   task automatic chk_reset(input int d, input string nm);
      chk({nm, "_dat"}, dat[d], 32'h0);
      chk({nm, "_ack"}, 32'(ack[d]), 32'h0);
      chk({nm, "_err"}, 32'(err[d]), 32'h0);
      chk({nm, "_fadr"}, 32'(fadr[d]), 32'h0);
      chk({nm, "_fdo"}, (d == 0) ? 32'(fdo0) : 32'(fdo1), 32'h0);
      chk({nm, "_doe"}, 32'(doe[d]), 32'h0);
      chk({nm, "_ce"}, 32'(ce[d]), 32'h1);
      chk({nm, "_oe"}, 32'(oe[d]), 32'h1);
      chk({nm, "_we"}, 32'(fwe[d]), 32'h1);
      chk({nm, "_frst"}, 32'(frst[d]), 32'h0);
   endtask

   task automatic do_read(input int d, input logic [31:0] a, input logic [31:0] exp,
                          input int lat, input string nm);
      int ack_cyc, acks, ws, nb, step;
      logic [31:0] base;
      ws = (d == 0) ? 5 : 2;
      nb = (d == 0) ? 4 : 2;
      step = (d == 0) ? 1 : 2;
      base = a & 32'hFFFF_FFFC;
      ack_cyc = -1;
      acks = 0;
      @(posedge clk); #1;
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b0; adr[d] = a;
      for (int c = 0; c < lat + 4; c++) begin
         @(negedge clk);
         for (int k = 0; k < nb; k++)
            if (c == 1 + k * (ws + 1)) begin
               chk({nm, "_adr"}, 32'(fadr[d]), base + 32'(k * step));
               chk({nm, "_oe"}, 32'(oe[d]), 32'h0);
            end
         if (ack[d]) begin
            acks++;
            if (ack_cyc < 0) begin
               ack_cyc = c;
               chk({nm, "_dat"}, dat[d], exp);
            end
         end
         @(posedge clk); #1;
         if (ack_cyc >= 0) begin cyc[d] = 1'b0; stb[d] = 1'b0; end
      end
      chk({nm, "_lat"}, ack_cyc, lat);
      chk({nm, "_nack"}, acks, 32'd1);
      chk({nm, "_hold"}, dat[d], exp);
      chk({nm, "_ce"}, 32'(ce[d]), 32'h1);
      cyc[d] = 1'b0; stb[d] = 1'b0;
   endtask

   typedef struct {
      int          d;
      logic [31:0] a;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t tv[5];

   initial begin
      int acks, errs, wl, doe_n, c1, c2;
      logic [31:0] prev;
      logic [31:0] ra;
      int rd;

      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      mem[10'h100] = 8'hDE; mem[10'h101] = 8'hAD; mem[10'h102] = 8'hBE; mem[10'h103] = 8'hEF;
      mem[10'h200] = 8'h12; mem[10'h201] = 8'h34; mem[10'h202] = 8'h56; mem[10'h203] = 8'h78;

      tv[0] = '{0, 32'h101, 32'hDEADBEEF, 25};
      tv[1] = '{1, 32'h202, 32'h12345678, 7};
      tv[2] = '{0, 32'h203, 32'h12345678, 25};
      tv[3] = '{1, 32'h100, 32'hDEADBEEF, 7};
      tv[4] = '{0, 32'h100, 32'hDEADBEEF, 25};

      for (int d = 0; d < 2; d++) begin
         cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; adr[d] = '0; wdat[d] = '0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset(0, "rst0");
      chk_reset(1, "rst1");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("frst_rel", 32'(frst[0]), 32'h1);

      for (int i = 0; i < 5; i++)
         do_read(tv[i].d, tv[i].a, tv[i].exp, tv[i].lat, "tv");

      // Strobe dropped in cycle 10 of a read: abort without ack, data kept.
      prev = dat[0];
      acks = 0;
      @(posedge clk); #1;
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h200;
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         if (ack[0]) acks++;
         if (c == 10) chk("abort_ce_pre", 32'(ce[0]), 32'h0);
         if (c == 11) chk("abort_ce", 32'(ce[0]), 32'h1);
         @(posedge clk); #1;
         if (c == 9) stb[0] = 1'b0;
      end
      cyc[0] = 1'b0;
      chk("abort_nack", acks, 32'd0);
      chk("abort_dat", dat[0], prev);

      // Reset mid-read, then a clean read.
      @(posedge clk); #1;
      cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h101;
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1; cyc[0] = 1'b0; stb[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_reset(0, "midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      do_read(0, 32'h101, 32'hDEADBEEF, 25, "postrst");

      // Command write of 0xA5 to 0x55.
      acks = 0; errs = 0; wl = 0; doe_n = 0;
      @(posedge clk); #1;
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h55; wdat[0] = 32'hA5;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!fwe[0]) begin
            wl++;
            chk("wr_fdo", 32'(fdo0), 32'hA5);
            chk("wr_fadr", 32'(fadr[0]), 32'h55);
         end
         if (doe[0]) doe_n++;
         if (ack[0]) acks++;
         if (err[0]) errs++;
         @(posedge clk); #1;
         if (acks > 0 || errs > 0) begin cyc[0] = 1'b0; stb[0] = 1'b0; end
      end
      cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
`ifdef WB_FLASH_WRITE_EN
      chk("wr_we_low", wl, 32'd5);
      chk("wr_acks", acks, 32'd1);
      chk("wr_errs", errs, 32'd0);
      chk("wr_doe", doe_n, 32'd7);
`else
      chk("wr_we_low", wl, 32'd0);
      chk("wr_acks", acks, 32'd0);
      chk("wr_errs", errs, 32'd1);
      chk("wr_doe", doe_n, 32'd0);
`endif

      // Back-to-back: strobe held through the ack starts a second read at once.
      acks = 0; c1 = -1; c2 = -1;
      @(posedge clk); #1;
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h202;
      for (int c = 0; c < 22; c++) begin
         @(negedge clk);
         if (ack[1]) begin
            acks++;
            if (c1 < 0) c1 = c; else if (c2 < 0) c2 = c;
            chk("b2b_dat", dat[1], 32'h12345678);
         end
         @(posedge clk); #1;
         if (acks >= 2) begin cyc[1] = 1'b0; stb[1] = 1'b0; end
      end
      cyc[1] = 1'b0; stb[1] = 1'b0;
      chk("b2b_first", c1, 32'd7);
      chk("b2b_second", c2, 32'd15);
      chk("b2b_count", acks, 32'd2);

      // Random reads against the flash-image model.
      for (int i = 0; i < 20; i++) begin
         rd = int'($urandom_range(0, 1));
         ra = 32'($urandom_range(0, 1023));
         do_read(rd, ra, model_rd(ra), model_lat(rd), "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
